// File: rtl/sort_stream16.sv
// rtl/sort_stream16.sv - block-streaming front end for a combinational bitonic sorter
// Optional flush port enabled by SORT_STREAM_FLUSH_EN.
module sort_stream16 #(
  parameter int K = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SORT_STREAM_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [15:0]       in_data,
  input  logic              in_dir,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [16*K-1:0]   sort_in_array,
  output logic              sort_dir,
  input  logic [16*K-1:0]   sort_out_array,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     load_cnt;
  logic [CW-1:0]     out_cnt;
  logic [16*K-1:0]   out_buf;
  logic              flush_i;

`ifdef SORT_STREAM_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Handshake flags decode from state only; flush gates in_ready so its concurrent word is dropped.
  assign in_ready  = (state == LOAD) && !flush_i;
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (out_cnt == LAST_IDX);
  assign out_data  = out_buf[16*int'(out_cnt) +: 16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      load_cnt      <= '0;
      out_cnt       <= '0;
      sort_in_array <= '0;
      sort_dir      <= 1'b0;
      out_buf       <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (flush_i) begin
            load_cnt <= '0;
          end else if (in_valid) begin
            sort_in_array[16*int'(load_cnt) +: 16] <= in_data;
            if (load_cnt == '0) sort_dir <= in_dir;
            if (load_cnt == LAST_IDX) begin
              load_cnt <= '0;
              state    <= SORT;
            end else begin
              load_cnt <= load_cnt + CW'(1);
            end
          end
        end
        SORT: begin
          out_buf <= sort_out_array;
          out_cnt <= '0;
          state   <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_cnt == LAST_IDX) begin
              out_cnt  <= '0;
              load_cnt <= '0;
              state    <= LOAD;
            end else begin
              out_cnt <= out_cnt + CW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_stream16.sv
// tb/tb_sort_stream16.sv - directed self-checking bench for sort_stream16
// Exercises the flush scenario when SORT_STREAM_FLUSH_EN is defined.
module tb_sort_stream16;
  localparam int K = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     in_data;
  logic            in_dir;
  logic            in_valid;
  logic            in_ready;
  logic [16*K-1:0] sort_in_array;
  logic            sort_dir;
  logic [16*K-1:0] sort_out_array;
  logic [15:0]     out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
`ifdef SORT_STREAM_FLUSH_EN
  logic            flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]     blk     [K];
  logic [15:0]     exp_out [K];
  logic [16*K-1:0] exp_arr;

  always #5 clk = ~clk;

  sort_stream16 #(.K(K)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef SORT_STREAM_FLUSH_EN
    .flush          (flush),
`endif
    .in_data        (in_data),
    .in_dir         (in_dir),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .sort_in_array  (sort_in_array),
    .sort_dir       (sort_dir),
    .sort_out_array (sort_out_array),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  // Stand-in for the downstream bitonic network: any correct sort will do.
  function automatic logic [16*K-1:0] sort_fn(input logic [16*K-1:0] a, input logic asc);
    logic [15:0] w [K];
    logic [15:0] t;
    logic [16*K-1:0] r;
    for (int i = 0; i < K; i++) w[i] = a[16*i +: 16];
    for (int i = 0; i < K - 1; i++)
      for (int j = 0; j < K - 1 - i; j++)
        if (asc ? (w[j] > w[j+1]) : (w[j] < w[j+1])) begin
          t = w[j]; w[j] = w[j+1]; w[j+1] = t;
        end
    for (int i = 0; i < K; i++) r[16*i +: 16] = w[i];
    return r;
  endfunction

  assign sort_out_array = sort_fn(sort_in_array, sort_dir);

  task automatic check(input string tag, input logic [16*K-1:0] obs, input logic [16*K-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams blk[] back to back; in_dir flips after word 0 to prove it is latched only once.
  task automatic load_block(input logic dir, input bit keep_valid);
    for (int j = 0; j < K; j++) begin
      exp_arr[16*j +: 16] = blk[j];
      in_valid = 1'b1;
      in_data  = blk[j];
      in_dir   = (j == 0) ? dir : ~dir;
      check("load_in_ready", in_ready, 1);
      step();
      check("load_sort_dir", sort_dir, dir);
    end
    if (keep_valid) begin
      in_data = 16'hFFFF;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic drain_block(input bit stall, input bit hold_chk, input logic dir);
    bit [3:0] pat = 4'b1001;
    bit p;
    int idx = 0;
    int cyc = 0;
    check("sort_out_valid", out_valid, 0);
    check("sort_in_ready", in_ready, 0);
    if (hold_chk) check("sort_hold", sort_in_array, exp_arr);
    step();
    while (idx < K && cyc < 200) begin
      p = stall ? pat[cyc % 4] : 1'b1;
      out_ready = p;
      check("drain_out_valid", out_valid, 1);
      check("drain_out_data", out_data, exp_out[idx]);
      check("drain_out_last", out_last, (idx == K - 1));
      check("drain_in_ready", in_ready, 0);
      check("drain_sort_dir", sort_dir, dir);
      if (hold_chk) check("drain_hold", sort_in_array, exp_arr);
      step();
      if (p) idx++;
      cyc++;
    end
    check("drain_count", idx, K);
    check("end_out_valid", out_valid, 0);
    check("end_in_ready", in_ready, 1);
    if (hold_chk) check("end_hold", sort_in_array, exp_arr);
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef SORT_STREAM_FLUSH_EN
    flush     = 1'b0;
`endif
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sort_dir", sort_dir, 0);
    check("rst_sort_in", sort_in_array, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Ascending, reversed input
    for (int j = 0; j < K; j++) begin blk[j] = 16'(15 - j); exp_out[j] = 16'(j); end
    load_block(1'b1, 1'b0);
    drain_block(1'b0, 1'b0, 1'b1);

    // Descending, ascending input
    for (int j = 0; j < K; j++) begin blk[j] = 16'(j); exp_out[j] = 16'(15 - j); end
    load_block(1'b0, 1'b0);
    drain_block(1'b0, 1'b0, 1'b0);

    // Output back-pressure 1,0,0,1 on a permuted block
    for (int j = 0; j < K; j++) begin blk[j] = 16'h0100 + 16'((j * 5) % 16); exp_out[j] = 16'h0100 + 16'(j); end
    load_block(1'b1, 1'b0);
    drain_block(1'b1, 1'b0, 1'b1);

    // in_valid held with 0xFFFF through SORT and DRAIN
    for (int j = 0; j < K; j++) begin blk[j] = 16'h2000 + 16'(15 - j); exp_out[j] = 16'h2000 + 16'(j); end
    load_block(1'b1, 1'b1);
    drain_block(1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;

    // Reset after 7 words
    for (int j = 0; j < 7; j++) begin
      in_valid = 1'b1; in_data = 16'h5000 + 16'(j); in_dir = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sort_in", sort_in_array, 0);
    step();
    rst_n = 1'b1;
    step();
    for (int j = 0; j < K; j++) begin blk[j] = 16'h0300 + 16'((j * 3) % 16); exp_out[j] = 16'h030F - 16'(j); end
    load_block(1'b0, 1'b0);
    drain_block(1'b0, 1'b0, 1'b0);

`ifdef SORT_STREAM_FLUSH_EN
    // Flush after 5 words, concurrent with a 0x1234 word that must be dropped
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_data = 16'h0777; in_dir = 1'b0;
      step();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    for (int j = 0; j < K; j++) begin blk[j] = 16'h0400 + 16'(15 - j); exp_out[j] = 16'h0400 + 16'(j); end
    load_block(1'b1, 1'b0);
    drain_block(1'b0, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_stream16.md
SORT_STREAM16 -- requirements
Module: sort_stream16

Interface
REQ-001 Parameter K SHALL be: K, default 16, number of 16-bit words per sort block; legal values are powers of two with K >= 2.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n SHALL be: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port in_data SHALL be: in_data  input  16  input word.
REQ-005 Port in_dir SHALL be: in_dir  input  1  sort direction (1 = ascending), sampled with the first word of each block.
REQ-006 Port in_valid SHALL be: in_valid  input  1  in_data/in_dir valid.
REQ-007 Port in_ready SHALL be: in_ready  output  1  block can accept a word.
REQ-008 Port sort_in_array SHALL be: sort_in_array  output  16*K  registered word array presented to the downstream bitonic sorter.
REQ-009 Port sort_dir SHALL be: sort_dir  output  1  registered direction presented to the sorter.
REQ-010 Port sort_out_array SHALL be: sort_out_array  input  16*K  combinational sorter result.
REQ-011 Port out_data SHALL be: out_data  output  16  sorted output word.
REQ-012 Port out_valid SHALL be: out_valid  output  1  out_data valid.
REQ-013 Port out_ready SHALL be: out_ready  input  1  consumer accepts out_data.
REQ-014 Port out_last SHALL be: out_last  output  1  marks the final word (index K-1) of a block.

Function
REQ-015 A transfer SHALL occur on a rising edge where valid and ready are both 1, on both the input and the output side.
REQ-016 The FSM SHALL have exactly three states: LOAD, SORT and DRAIN.
REQ-017 LOAD: in_ready = 1; the j-th accepted word (j = 0 first) SHALL be written to sort_in_array[16j+15:16j].
REQ-018 LOAD: in_dir SHALL be latched into sort_dir when j = 0.
REQ-019 LOAD: a load counter SHALL count 0..K-1, and the K-th accepted word SHALL move the FSM to SORT.
REQ-020 SORT: SHALL last exactly one cycle with in_ready = 0 and out_valid = 0; at the end of that cycle sort_out_array SHALL be captured into an internal K-word output buffer and the FSM SHALL go to DRAIN.
REQ-021 DRAIN: out_valid = 1 and out_data = buffer slice i, for i = 0..K-1 in order; i SHALL advance only on an output transfer.
REQ-022 DRAIN: out_last SHALL equal 1 exactly when i = K-1.
REQ-023 DRAIN: the transfer of word K-1 SHALL return the FSM to LOAD and clear both counters.
REQ-024 DRAIN: in_ready SHALL be 0; no input overlap.
REQ-025 While out_ready = 0 in DRAIN, out_data, out_last and out_valid SHALL hold stable.
REQ-026 Minimum latency SHALL be 2 cycles: the first output word is valid 2 cycles after the edge accepting input word K-1 (that edge plus the SORT cycle).
REQ-027 Minimum period SHALL be 2K+1 cycles per block.
REQ-028 in_valid in SORT or DRAIN SHALL be ignored, and no data SHALL be written.
REQ-029 sort_in_array and sort_dir SHALL remain stable from SORT until the next block's first accepted word.
REQ-030 in_ready, out_valid and out_last SHALL decode from registered state only; there SHALL be no combinational path from in_valid or out_ready to any output.
REQ-031 With a conforming bitonic sorter attached, a block loaded with sort_dir = 1 SHALL emit nondecreasing words and with sort_dir = 0 SHALL emit nonincreasing words.

Reset
REQ-032 Asserting rst_n = 0 SHALL immediately set the state to LOAD, set both counters to 0, and clear sort_in_array, sort_dir, the output buffer and out_data to 0.
REQ-033 While rst_n = 0, outputs SHALL be in_ready = 1, out_valid = 0 and out_last = 0.
REQ-034 Reset asserted mid-LOAD or mid-DRAIN SHALL discard the partial block with no further output.
REQ-035 The first word accepted after release SHALL be stored as word 0.

Configuration
REQ-036 Macro SORT_STREAM_FLUSH_EN, when defined, SHALL add port flush (input, 1 bit).
REQ-037 With SORT_STREAM_FLUSH_EN defined, flush = 1 in LOAD SHALL clear the load counter at the edge, discarding words already loaded, and SHALL drive in_ready = 0 that cycle so a simultaneous in_valid word is dropped.
REQ-038 With SORT_STREAM_FLUSH_EN defined, flush SHALL be ignored in SORT and DRAIN.
REQ-039 Without SORT_STREAM_FLUSH_EN, the flush port SHALL be absent and behaviour SHALL be identical to flush tied to 0.

Verification
REQ-040 The bench SHALL cover: K=16, dir=1, words 15..0 streamed back-to-back, out_ready=1 -> outputs 0..15 in order, out_last only on 15, first out_valid 2 cycles after the last input transfer.
REQ-041 The bench SHALL cover: K=16, dir=0, words 0..15 -> outputs 15..0; sort_dir = 0 for the whole block.
REQ-042 The bench SHALL cover: out_ready toggling 1,0,0,1 during DRAIN -> out_data is held during stalls, no word is lost or duplicated, 16 transfers total.
REQ-043 The bench SHALL cover: in_valid held high through SORT/DRAIN with data 0xFFFF -> in_ready = 0 and sort_in_array is unchanged until the next LOAD.
REQ-044 The bench SHALL cover: rst_n pulsed low after 7 input words -> in_ready = 1, out_valid = 0; a following block of 16 words sorts correctly with no stale data.
REQ-045 The bench SHALL cover, with SORT_STREAM_FLUSH_EN: flush after 5 words, concurrent with in_valid carrying 0x1234 -> those 6 words are discarded, the next 16 words form the block, and 0x1234 does not appear in the output.
